// File: rtl/rv32i_trace_pkg.sv
// rtl/rv32i_trace_pkg.sv - shared types and RV32I immediate decode for the trace monitor
package rv32i_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE  = 2'd0,
        HC_END   = 2'd1,
        HC_HANG  = 2'd2,
        HC_LIMIT = 2'd3
    } halt_cause_e;

    // Consumer-side view of one record at XLEN=32; the FIFO stores the same fields flat, sized by N.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] wb;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [3:0]  flags;
    } trace_rec_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv32i_trace_fifo.sv
// rtl/rv32i_trace_fifo.sv - synchronous first-word-fall-through FIFO with full/empty/level
module rv32i_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign o_empty   = (o_level == '0);
    assign o_full    = (o_level == (AW+1)'(DEPTH));
    assign do_rd     = i_rd_en && !o_empty;
    // A pop frees the slot the write lands in, so a full FIFO still accepts a simultaneous push.
    assign do_wr     = i_wr_en && (!o_full || do_rd);
    assign o_rd_data = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= i_wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   o_level <= o_level + (AW+1)'(1);
                2'b01:   o_level <= o_level - (AW+1)'(1);
                default: o_level <= o_level;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_trace_monitor.sv
// rtl/rv32i_trace_monitor.sv - retirement-trace monitor with halt detection; RV_TRACE_MEM_EN adds memory fields
module rv32i_trace_monitor
    import rv32i_trace_pkg::*;
#(
    parameter int          N          = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter int          HANG_LIMIT = 10,
    parameter int          END_PC     = 304,
    parameter int unsigned MAX_INST   = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [N-1:0]                  i_pc,
    input  logic [31:0]                   i_instr,
    input  logic [N-1:0]                  i_rd1,
    input  logic [N-1:0]                  i_wb_data,
    input  logic [4:0]                    i_rd_addr,
    input  logic                          i_reg_write,
    input  logic                          i_mem_read,
    input  logic                          i_mem_write,
    input  logic                          i_branch_taken,
    input  logic                          i_jal,
    input  logic                          i_jalr,
    output logic                          o_trc_valid,
    input  logic                          i_trc_ready,
    output logic [N-1:0]                  o_trc_pc,
    output logic [N-1:0]                  o_trc_next_pc,
    output logic [N-1:0]                  o_trc_wb,
    output logic [31:0]                   o_trc_instr,
    output logic [4:0]                    o_trc_rd,
    output logic [3:0]                    o_trc_flags,
    output logic [31:0]                   o_inst_count,
    output logic [15:0]                   o_drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [1:0]                    o_state,
    output logic [1:0]                    o_halt_cause
`ifdef RV_TRACE_MEM_EN
    ,
    input  logic [N-1:0]                  i_mem_addr,
    input  logic [N-1:0]                  i_mem_wdata,
    output logic [N-1:0]                  o_trc_mem_addr,
    output logic [N-1:0]                  o_trc_mem_data
`endif
);
`ifdef RV_TRACE_MEM_EN
    localparam int REC_W = 5*N + 41;
`else
    localparam int REC_W = 3*N + 41;
`endif

    state_e        state, state_nxt;
    halt_cause_e   cause, cause_nxt;
    logic [N-1:0]  prev_pc, pc_plus4, next_pc, imm_i_n, imm_b_n, imm_j_n;
    logic [31:0]   same_cnt, same_nxt;
    logic          capture, pop, jump, fifo_full, fifo_empty;
    logic          end_hit, hang_hit, limit_hit;
    logic [REC_W-1:0] rec_in, rec_out;

    assign imm_i_n  = N'(signed'(imm_i(i_instr)));
    assign imm_b_n  = N'(signed'(imm_b(i_instr)));
    assign imm_j_n  = N'(signed'(imm_j(i_instr)));
    assign pc_plus4 = i_pc + N'(4);

    always_comb begin
        next_pc = pc_plus4;
        if (i_jalr)              next_pc = (i_rd1 + imm_i_n) & ~N'(1);
        else if (i_jal)          next_pc = i_pc + imm_j_n;
        else if (i_branch_taken) next_pc = i_pc + imm_b_n;
    end
    assign jump = (next_pc != pc_plus4);

    assign capture   = i_en && (state != ST_HALT);
    assign pop       = o_trc_valid && i_trc_ready;
    // PC 0 is the reset vector, so a repeat there is not treated as a stuck loop.
    assign same_nxt  = ((i_pc == prev_pc) && (i_pc != '0)) ? same_cnt + 32'd1 : 32'd0;
    assign end_hit   = (i_pc >= N'(END_PC));
    assign hang_hit  = (same_nxt > 32'(HANG_LIMIT));
    assign limit_hit = (MAX_INST != 0) && ((o_inst_count + 32'd1) == 32'(MAX_INST));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            cause <= HC_NONE;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        case (state)
            ST_IDLE: if (i_en) state_nxt = ST_RUN;
            default: state_nxt = state;
        endcase
        if (capture && (end_hit || hang_hit || limit_hit)) begin
            state_nxt = ST_HALT;
            cause_nxt = end_hit ? HC_END : (hang_hit ? HC_HANG : HC_LIMIT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prev_pc      <= '0;
            same_cnt     <= '0;
            o_inst_count <= '0;
            o_drop_count <= '0;
        end else if (capture) begin
            prev_pc      <= i_pc;
            same_cnt     <= same_nxt;
            o_inst_count <= o_inst_count + 32'd1;
            if (fifo_full && !pop && (o_drop_count != 16'hFFFF))
                o_drop_count <= o_drop_count + 16'd1;
        end
    end

`ifdef RV_TRACE_MEM_EN
    logic mem_sel;
    assign mem_sel = i_mem_read || i_mem_write;
    assign rec_in  = {i_pc, next_pc, i_wb_data, i_instr, i_rd_addr,
                      jump, i_reg_write, i_mem_read, i_mem_write,
                      mem_sel ? i_mem_addr : '0, mem_sel ? i_mem_wdata : '0};
    assign {o_trc_pc, o_trc_next_pc, o_trc_wb, o_trc_instr, o_trc_rd, o_trc_flags,
            o_trc_mem_addr, o_trc_mem_data} = rec_out;
`else
    assign rec_in  = {i_pc, next_pc, i_wb_data, i_instr, i_rd_addr,
                      jump, i_reg_write, i_mem_read, i_mem_write};
    assign {o_trc_pc, o_trc_next_pc, o_trc_wb, o_trc_instr, o_trc_rd, o_trc_flags} = rec_out;
`endif

    rv32i_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (capture),
        .i_wr_data (rec_in),
        .i_rd_en   (i_trc_ready),
        .o_rd_data (rec_out),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_level   (o_fifo_level)
    );

    assign o_trc_valid  = !fifo_empty;
    assign o_state      = state;
    assign o_halt_cause = cause;

endmodule

// File: tb/tb_rv32i_trace_monitor.sv
// tb/tb_rv32i_trace_monitor.sv - directed self-checking bench for rv32i_trace_monitor
module tb_rv32i_trace_monitor;
    logic        clk = 1'b0;
    logic        rst_n, en, ready;
    logic [31:0] pc, instr, rd1, wb;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, br, jal, jalr;
    logic        trc_valid;
    logic [31:0] trc_pc, trc_next_pc, trc_wb, trc_instr, inst_count;
    logic [4:0]  trc_rd, fifo_level;
    logic [3:0]  trc_flags;
    logic [15:0] drop_count;
    logic [1:0]  state, cause;
`ifdef RV_TRACE_MEM_EN
    logic [31:0] mem_addr, mem_wdata, trc_mem_addr, trc_mem_data;
`endif
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rv32i_trace_monitor dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pc(pc), .i_instr(instr),
        .i_rd1(rd1), .i_wb_data(wb), .i_rd_addr(rd), .i_reg_write(reg_write),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_branch_taken(br),
        .i_jal(jal), .i_jalr(jalr), .o_trc_valid(trc_valid), .i_trc_ready(ready),
        .o_trc_pc(trc_pc), .o_trc_next_pc(trc_next_pc), .o_trc_wb(trc_wb),
        .o_trc_instr(trc_instr), .o_trc_rd(trc_rd), .o_trc_flags(trc_flags),
        .o_inst_count(inst_count), .o_drop_count(drop_count), .o_fifo_level(fifo_level),
        .o_state(state), .o_halt_cause(cause)
`ifdef RV_TRACE_MEM_EN
        , .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
        .o_trc_mem_addr(trc_mem_addr), .o_trc_mem_data(trc_mem_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; pc = 0; instr = 32'h13; rd1 = 0; wb = 0; rd = 0;
        reg_write = 0; mem_read = 0; mem_write = 0; br = 0; jal = 0; jalr = 0; ready = 0;
`ifdef RV_TRACE_MEM_EN
        mem_addr = 0; mem_wdata = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        total++; if (trc_valid !== 1'b0)    $display("FAIL reset_valid: got %0b want 0", trc_valid); else passed++;
        total++; if (fifo_level !== 5'd0)   $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
        total++; if (state !== 2'd0)        $display("FAIL reset_state: got %0d want 0", state); else passed++;
        total++; if (cause !== 2'd0)        $display("FAIL reset_cause: got %0d want 0", cause); else passed++;
        total++; if (inst_count !== 32'd0)  $display("FAIL reset_count: got %0d want 0", inst_count); else passed++;
        total++; if (trc_pc !== 32'd0)      $display("FAIL reset_trc_pc: got %h want 0", trc_pc); else passed++;
        rst_n = 1;
    endtask

    task automatic test_sequential();
        do_reset();
        en = 1; instr = 32'h00500093; reg_write = 1; rd = 5'd1; wb = 32'd5;
        for (int k = 0; k < 3; k++) begin
            pc = 32'(4 * k);
            tick();
        end
        idle_inputs();
        total++; if (inst_count !== 32'd3) $display("FAIL seq_count: got %0d want 3", inst_count); else passed++;
        total++; if (fifo_level !== 5'd3)  $display("FAIL seq_level: got %0d want 3", fifo_level); else passed++;
        total++; if (state !== 2'd1)       $display("FAIL seq_state: got %0d want 1", state); else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (trc_valid !== 1'b1 || trc_pc !== 32'(4*k) || trc_next_pc !== 32'(4*k+4) ||
                trc_flags !== 4'b0100 || trc_rd !== 5'd1 || trc_wb !== 32'd5 || trc_instr !== 32'h00500093)
                $display("FAIL seq_rec%0d: got v=%0b pc=%h npc=%h fl=%b rd=%0d wb=%h ins=%h want v=1 pc=%h npc=%h fl=0100 rd=1 wb=5 ins=00500093",
                         k, trc_valid, trc_pc, trc_next_pc, trc_flags, trc_rd, trc_wb, trc_instr, 4*k, 4*k+4);
            else passed++;
            ready = 1;
            tick();
        end
        total++; if (trc_valid !== 1'b0) $display("FAIL seq_drained: got %0b want 0", trc_valid); else passed++;
        ready = 0;
    endtask

    task automatic test_jal_end();
        do_reset();
        en = 1; pc = 32'd296; instr = 32'h0080006F; jal = 1;
        tick();
        jal = 0; pc = 32'd304; instr = 32'h13;
        tick();
        en = 0;
        total++; if (state !== 2'd2)       $display("FAIL end_state: got %0d want 2", state); else passed++;
        total++; if (cause !== 2'd1)       $display("FAIL end_cause: got %0d want 1", cause); else passed++;
        total++; if (fifo_level !== 5'd2)  $display("FAIL end_level: got %0d want 2", fifo_level); else passed++;
        total++; if (trc_next_pc !== 32'h130 || trc_flags !== 4'b1000)
            $display("FAIL jal_rec: got npc=%h fl=%b want npc=00000130 fl=1000", trc_next_pc, trc_flags); else passed++;
        ready = 1;
        tick();
        ready = 0;
        total++; if (trc_pc !== 32'd304 || trc_next_pc !== 32'd308)
            $display("FAIL end_rec: got pc=%0d npc=%0d want pc=304 npc=308", trc_pc, trc_next_pc); else passed++;
        en = 1; pc = 32'h8;
        tick();
        en = 0;
        total++; if (inst_count !== 32'd2 || fifo_level !== 5'd1)
            $display("FAIL halt_sticky: got cnt=%0d lvl=%0d want cnt=2 lvl=1", inst_count, fifo_level); else passed++;
    endtask

    task automatic test_jalr_branch();
        logic [31:0] exp_npc [4];
        logic [3:0]  exp_fl  [4];
        do_reset();
        exp_npc[0] = 32'hCC; exp_fl[0] = 4'b1000;
        exp_npc[1] = 32'h1C; exp_fl[1] = 4'b1000;
        exp_npc[2] = 32'h28; exp_fl[2] = 4'b0000;
        exp_npc[3] = 32'hCC; exp_fl[3] = 4'b0000;
        en = 1; pc = 32'h10; instr = 32'h00408067; jalr = 1; rd1 = 32'hC9;
        tick();
        jalr = 0; pc = 32'h20; instr = 32'hFE000EE3; br = 1;
        tick();
        br = 0; pc = 32'h24;
        tick();
        pc = 32'hC8; instr = 32'h00408067; jalr = 1;
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (trc_next_pc !== exp_npc[k] || trc_flags !== exp_fl[k])
                $display("FAIL jump_rec%0d: got npc=%h fl=%b want npc=%h fl=%b", k, trc_next_pc, trc_flags, exp_npc[k], exp_fl[k]);
            else passed++;
            ready = 1;
            tick();
        end
        ready = 0;
    endtask

    task automatic test_hang();
        do_reset();
        en = 1; pc = 32'h40;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 11) begin
                total++; if (state !== 2'd1) $display("FAIL hang_early: got state %0d want 1", state); else passed++;
            end
            if (k == 12) begin
                total++; if (state !== 2'd2 || cause !== 2'd2)
                    $display("FAIL hang_trip: got state=%0d cause=%0d want 2/2", state, cause); else passed++;
            end
        end
        en = 0;
        total++; if (inst_count !== 32'd12 || fifo_level !== 5'd12)
            $display("FAIL hang_ignored: got cnt=%0d lvl=%0d want 12/12", inst_count, fifo_level); else passed++;
    endtask

    task automatic test_fifo_full();
        do_reset();
        en = 1;
        for (int k = 0; k < 20; k++) begin
            pc = 32'(4 * (k + 1));
            tick();
        end
        en = 0;
        total++; if (fifo_level !== 5'd16) $display("FAIL full_level: got %0d want 16", fifo_level); else passed++;
        total++; if (drop_count !== 16'd4) $display("FAIL full_drop: got %0d want 4", drop_count); else passed++;
        total++; if (inst_count !== 32'd20) $display("FAIL full_count: got %0d want 20", inst_count); else passed++;
        ready = 1;
        for (int k = 0; k < 16; k++) begin
            total++; if (trc_pc !== 32'(4 * (k + 1)))
                $display("FAIL drain%0d: got %h want %h", k, trc_pc, 4 * (k + 1)); else passed++;
            tick();
        end
        total++; if (trc_valid !== 1'b0) $display("FAIL drain_empty: got %0b want 0", trc_valid); else passed++;
        ready = 0; en = 1;
        for (int k = 0; k < 16; k++) begin
            pc = 32'(32'h60 + 4 * k);
            tick();
        end
        ready = 1; pc = 32'hA0;
        tick();
        ready = 0; en = 0;
        total++; if (drop_count !== 16'd4 || fifo_level !== 5'd16)
            $display("FAIL pop_push: got drop=%0d lvl=%0d want 4/16", drop_count, fifo_level); else passed++;
        total++; if (trc_pc !== 32'h64) $display("FAIL pop_push_head: got %h want 00000064", trc_pc); else passed++;
    endtask

    task automatic test_midrun_reset();
        ready = 1;
        for (int k = 0; k < 11; k++) tick();
        ready = 0;
        total++; if (fifo_level !== 5'd5) $display("FAIL pre_reset_level: got %0d want 5", fifo_level); else passed++;
        rst_n = 0; en = 1; pc = 32'h200;
        tick();
        rst_n = 1; en = 0;
        total++; if (trc_valid !== 1'b0 || fifo_level !== 5'd0 || state !== 2'd0 ||
                     inst_count !== 32'd0 || drop_count !== 16'd0)
            $display("FAIL midrun_reset: got v=%0b lvl=%0d st=%0d cnt=%0d drop=%0d want all 0",
                     trc_valid, fifo_level, state, inst_count, drop_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jal_end();
        test_jalr_branch();
        test_hang();
        test_fifo_full();
        test_midrun_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
